// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module : lsu_pkg
//  Brief  : Shared funct3 codes, FSM state encoding and helpers for the LSU.
//  Rev    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam int LANE_BYTES = 4;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_RD     = 3'd1;
    localparam state_t S_WR     = 3'd2;
    localparam state_t S_RMW_RD = 3'd3;
    localparam state_t S_RMW_WR = 3'd4;
    localparam state_t S_RESP   = 3'd5;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                F3_SB, F3_SH, F3_SW: ok = 1'b1;
                default:             ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module : lsu_align
//  Brief  : Combinational load lane extract/extend and store lane merge.
//  Rev    : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [4:0]  w_shamt;
    logic [31:0] w_lane_word;
    logic [31:0] w_size_mask;
    logic [31:0] w_lane_mask;

    // One shift amount drives both the load extract and the store merge
    assign w_shamt     = {i_lane, 3'b000};
    assign w_lane_word = i_load_word >> w_shamt;
    assign w_lane_mask = w_size_mask << w_shamt;

    always_comb begin
        w_size_mask = 32'hFFFF_FFFF;
        case (i_funct3[1:0])
            2'b00:   w_size_mask = 32'h0000_00FF;
            2'b01:   w_size_mask = 32'h0000_FFFF;
            default: w_size_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        o_load_data = w_lane_word;
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_lane_word[7]}}, w_lane_word[7:0]};
            F3_LH:   o_load_data = {{16{w_lane_word[15]}}, w_lane_word[15:0]};
            F3_LBU:  o_load_data = {24'h0, w_lane_word[7:0]};
            F3_LHU:  o_load_data = {16'h0, w_lane_word[15:0]};
            default: o_load_data = w_lane_word;
        endcase
    end

    assign o_merged_word = (i_old_word & ~w_lane_mask)
                         | ((i_store_data << w_shamt) & w_lane_mask);

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module : lsu_mem_master
//  Brief  : RV32I load/store initiator on a word-wide, byte-enable-less bus.
//  Rev    : 1.0  initial release
// ============================================================================
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_SHIFT    = 2,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_read_cs,
    output logic        o_write_cs,
    output logic [31:0] o_address,
    output logic [31:0] o_memdat,
    input  logic [31:0] i_memdat
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_accept;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_fault;
    logic [31:0] w_addr_aligned;
    state_t      w_next_state;
    logic [31:0] w_load_data;
    logic [31:0] w_merged_word;

    assign o_req_ready  = (r_state == S_IDLE);
    assign w_accept     = i_req_valid & o_req_ready;
    assign o_resp_valid = (r_state == S_RESP);
    assign o_read_cs    = (r_state == S_RD) || (r_state == S_RMW_RD);
    assign o_write_cs   = (r_state == S_WR) || (r_state == S_RMW_WR);
    assign o_rdata      = r_rdata;
    assign o_fault      = r_fault;
    assign o_address    = r_addr >> ADDR_SHIFT;
    assign o_memdat     = (r_state == S_RMW_WR) ? w_merged_word : r_wdata;

    assign w_is_half    = (i_funct3[1:0] == 2'b01);
    assign w_is_word    = (i_funct3[1:0] == 2'b10);
    assign w_misaligned = (w_is_half & i_addr[0]) | (w_is_word & (|i_addr[1:0]));
    assign w_fault      = !f3_legal(i_req_we, i_funct3) || (MISALIGN_TRAP && w_misaligned);

    // Without trapping, the offending low bits are simply dropped
    assign w_addr_aligned = {i_addr[31:2],
                             i_addr[1] & ~w_is_word,
                             i_addr[0] & ~(w_is_half | w_is_word)};

    always_comb begin
        w_next_state = S_RESP;
        if (w_fault)
            w_next_state = S_RESP;
        else if (!i_req_we)
            w_next_state = S_RD;
        else if (i_funct3 == F3_SW)
            w_next_state = S_WR;
        else
            w_next_state = S_RMW_RD;
    end

    lsu_align u_align (
        .i_funct3      (r_funct3),
        .i_lane        (r_addr[1:0]),
        .i_load_word   (i_memdat),
        .i_old_word    (r_word),
        .i_store_data  (r_wdata),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= 32'h0;
            r_funct3 <= 3'b000;
            r_wdata  <= 32'h0;
            r_word   <= 32'h0;
            r_rdata  <= 32'h0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= w_addr_aligned;
                        r_funct3 <= i_funct3;
                        r_wdata  <= i_wdata;
                        r_fault  <= w_fault;
                        r_rdata  <= 32'h0;
                        r_state  <= w_next_state;
                    end
                end
                S_RD: begin
                    r_rdata <= w_load_data;
                    r_state <= S_RESP;
                end
                S_WR:     r_state <= S_RESP;
                S_RMW_RD: begin
                    r_word  <= i_memdat;
                    r_state <= S_RMW_WR;
                end
                S_RMW_WR: r_state <= S_RESP;
                S_RESP:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module : tb_lsu_mem_master
//  Brief  : Self-checking bench for lsu_mem_master against a byte-level model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_lsu_mem_master;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        req_valid, req_we, valid_nt;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        req_ready, resp_valid, fault, read_cs, write_cs;
    logic [31:0] rdata, address, memdat, memdat_in;
    logic        ready_nt, resp_nt, fault_nt, read_cs_nt, write_cs_nt;
    logic [31:0] rdata_nt, address_nt, memdat_nt, memdat_in_nt;

    logic [31:0] mem [0:2047];
    logic        led = 1'b0;
    logic [7:0]  rb  [0:8191];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lsu_mem_master #(.ADDR_SHIFT(2), .MISALIGN_TRAP(1'b1)) dut (
        .clock(clock), .rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
        .o_resp_valid(resp_valid), .o_rdata(rdata), .o_fault(fault),
        .o_read_cs(read_cs), .o_write_cs(write_cs), .o_address(address),
        .o_memdat(memdat), .i_memdat(memdat_in)
    );

    lsu_mem_master #(.ADDR_SHIFT(2), .MISALIGN_TRAP(1'b0)) dut_nt (
        .clock(clock), .rst(rst), .i_req_valid(valid_nt), .o_req_ready(ready_nt),
        .i_req_we(req_we), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
        .o_resp_valid(resp_nt), .o_rdata(rdata_nt), .o_fault(fault_nt),
        .o_read_cs(read_cs_nt), .o_write_cs(write_cs_nt), .o_address(address_nt),
        .o_memdat(memdat_nt), .i_memdat(memdat_in_nt)
    );

    assign memdat_in    = mem[address[10:0]];
    assign memdat_in_nt = mem[address_nt[10:0]];

    always @(posedge clock) begin
        if (write_cs) begin
            mem[address[10:0]] <= memdat;
            if (address == 32'h402) led <= memdat[0];
        end
    end

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural model: byte-addressed memory, access size from funct3
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit trap,
                         output logic [31:0] r, output logic flt, output int lat,
                         output int nrd, output int nwr, output int widx);
        int  size, ea;
        bit  legal, mis;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (int'(a) % size) != 0;
        r = 32'h0; flt = 1'b0; lat = 1; nrd = 0; nwr = 0; widx = 0;
        if (!legal || (trap && mis)) begin
            flt = 1'b1;
            return;
        end
        ea   = int'(a) - (int'(a) % size);
        widx = ea / 4;
        if (!we) begin
            for (int i = 0; i < size; i++) r |= 32'(rb[ea+i]) << (8*i);
            if (f3[2] == 1'b0 && size < 4 && r[8*size-1])
                r |= ~((32'd1 << (8*size)) - 32'd1);
            lat = 2; nrd = 1;
        end else begin
            for (int i = 0; i < size; i++) rb[ea+i] = wd[8*i +: 8];
            nrd = (size < 4) ? 1 : 0;
            nwr = 1;
            lat = (size < 4) ? 3 : 2;
        end
    endtask

    // Called at a negedge; returns at the negedge where resp_valid is seen
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag, output logic [31:0] got);
        logic [31:0] er, saddr;
        logic        ef;
        int          elat, erd, ewr, ew, lat, nrd, nwr, guard;
        model(we, f3, a, wd, 1'b1, er, ef, elat, erd, ewr, ew);
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        guard = 0;
        while (!req_ready && guard < 10) begin @(negedge clock); guard++; end
        @(posedge clock);
        @(negedge clock);
        lat = 1; nrd = 0; nwr = 0; saddr = 32'hFFFF_FFFF;
        while (!resp_valid && lat < 8) begin
            if (read_cs || write_cs) saddr = address;
            nrd += int'(read_cs);
            nwr += int'(write_cs);
            check({tag, "_busy_ready"}, {31'h0, req_ready}, 32'h0);
            req_we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            @(negedge clock);
            lat++;
        end
        req_valid = 1'b0;
        got = rdata;
        check({tag, "_lat"},   lat, elat);
        check({tag, "_rdata"}, rdata, er);
        check({tag, "_fault"}, {31'h0, fault}, {31'h0, ef});
        check({tag, "_nrd"},   nrd, erd);
        check({tag, "_nwr"},   nwr, ewr);
        check({tag, "_resp_cs"}, {30'h0, read_cs, write_cs}, 32'h0);
        if (erd + ewr > 0) check({tag, "_addr"}, saddr, ew);
        if (we && !ef) check({tag, "_mem"}, mem[ew[10:0]], ref_word(ew));
    endtask

    initial begin
        logic [31:0] got;
        int          guard;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8192; i++) rb[i] = 8'h0;
        mem[4] = 32'h4020A023;
        mem[9] = 32'h0000_0135;
        {rb[19], rb[18], rb[17], rb[16]} = 32'h4020A023;
        {rb[39], rb[38], rb[37], rb[36]} = 32'h0000_0135;
        req_valid = 1'b0; valid_nt = 1'b0; req_we = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;

        repeat (3) @(negedge clock);
        check("rst_ready",   {31'h0, req_ready}, 32'h1);
        check("rst_resp",    {31'h0, resp_valid}, 32'h0);
        check("rst_fault",   {31'h0, fault}, 32'h0);
        check("rst_cs",      {30'h0, read_cs, write_cs}, 32'h0);
        check("rst_rdata",   rdata, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_memdat",  memdat, 32'h0);
        rst = 1'b0;
        @(negedge clock);

        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw10", got);
        check("lw10_spec", got, 32'h4020A023);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, "lb11", got);
        check("lb11_spec", got, 32'hFFFF_FFA0);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, "lbu11", got);
        check("lbu11_spec", got, 32'h0000_00A0);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, "lhu12", got);
        check("lhu12_spec", got, 32'h0000_4020);
        do_req(1'b0, 3'b001, 32'h24, 32'h0, "lh24", got);
        check("lh24_spec", got, 32'h0000_0135);
        do_req(1'b1, 3'b000, 32'h11, 32'h55, "sb11", got);
        check("sb11_mem_spec", mem[4], 32'h40205523);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw10b", got);
        check("lw10b_spec", got, 32'h40205523);
        do_req(1'b1, 3'b010, 32'h1008, 32'h1, "sw_led", got);
        check("led", {31'h0, led}, 32'h1);
        do_req(1'b0, 3'b010, 32'h11, 32'h0, "lw_mis", got);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, "ld_f3_011", got);
        do_req(1'b1, 3'b100, 32'h10, 32'h7, "st_f3_100", got);
        do_req(1'b1, 3'b001, 32'h13, 32'h7, "sh_mis", got);

        // Non-trapping instance: misaligned LW reads the enclosing word
        req_we = 1'b0; funct3 = 3'b010; addr = 32'h11; valid_nt = 1'b1;
        @(posedge clock); @(negedge clock);
        valid_nt = 1'b0;
        check("nt_read_cs", {31'h0, read_cs_nt}, 32'h1);
        check("nt_address", address_nt, 32'h4);
        @(negedge clock);
        check("nt_resp",  {31'h0, resp_nt}, 32'h1);
        check("nt_fault", {31'h0, fault_nt}, 32'h0);
        check("nt_rdata", rdata_nt, ref_word(4));

        // Reset during the read half of an SH read-modify-write
        guard = 0;
        while (!req_ready && guard < 10) begin @(negedge clock); guard++; end
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b001; addr = 32'h20; wdata = 32'hBEEF;
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        check("rmw_rd_cs", {30'h0, read_cs, write_cs}, 32'h2);
        #1 rst = 1'b1;
        #1 check("rst_mid_cs", {30'h0, read_cs, write_cs}, 32'h0);
        @(posedge clock); @(negedge clock);
        rst = 1'b0;
        #1 check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mid_mem", mem[8], ref_word(8));
        @(negedge clock);
        check("rst_mid_mem2", mem[8], ref_word(8));

        for (int n = 0; n < 80; n++) begin
            logic [2:0]  rf;
            logic [31:0] ra;
            rf = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2);
            ra = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 255)) << 2) : 32'($urandom_range(0, 1023));
            do_req(1'($urandom), rf, ra, $urandom, $sformatf("rnd%0d", n), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
